// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - FSM state encoding and edge-counter sizing for freq_meter
package freq_meter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  // Holds the most edges a gate window can see: one rising edge per two cycles.
  function automatic int edge_cnt_width(input int gate_cyc);
    return $clog2(gate_cyc / 2 + 1);
  endfunction

endpackage

// File: rtl/sig_sync_edge.sv
// rtl/sig_sync_edge.sv - sig_in synchronizer, optional majority filter, rising-edge detect
// Optional filter: FREQ_METER_GLITCH_FILTER_EN
module sig_sync_edge
  import freq_meter_pkg::*;
(
  input  logic clk_in,
  input  logic rst_n,
  input  logic sig_in,
  output logic edge_now
);

  logic sync_q1;
  logic sync_q2;
  logic level;
  logic level_d;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= sig_in;
      sync_q2 <= sync_q1;
    end
  end

`ifdef FREQ_METER_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic       filt;

  // Majority of the current and two previous samples; adds two cycles of latency.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 2'b00;
      filt <= 1'b0;
    end else begin
      hist <= {hist[0], sync_q2};
      filt <= (sync_q2 & hist[0]) | (sync_q2 & hist[1]) | (hist[0] & hist[1]);
    end
  end

  assign level = filt;
`else
  assign level = sync_q2;
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  assign edge_now = level & ~level_d;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated edge-count frequency meter with valid/ready result and sticky overrun
// Optional glitch filter in sig_sync_edge: FREQ_METER_GLITCH_FILTER_EN
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CLK_IN_FREQ = 50_000_000,
  parameter int GATE_DIV    = 10,
  parameter int RES_W       = 32
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [RES_W-1:0] freq_hz,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             overrun
);

  localparam int GATE_CYC = CLK_IN_FREQ / GATE_DIV;
  localparam int GATE_W   = $clog2(GATE_CYC);
  localparam int EDGE_W   = edge_cnt_width(GATE_CYC);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYC - 1);
  localparam logic [EDGE_W-1:0] EDGE_MAX  = {EDGE_W{1'b1}};

  if (GATE_CYC < 4) begin : g_gate_too_short
    $fatal(1, "freq_meter: CLK_IN_FREQ/GATE_DIV must be at least 4");
  end

  state_t            state;
  logic [GATE_W-1:0] gate_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic              edge_now;
  logic              terminal;
  logic [RES_W-1:0]  result;

  sig_sync_edge u_sync (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .edge_now (edge_now)
  );

  assign terminal = (state == GATE) && (gate_cnt == GATE_LAST);

  // The edge arriving on the terminal cycle still belongs to this window.
  assign result = (RES_W'(edge_cnt) + RES_W'(edge_now)) * RES_W'(GATE_DIV);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) state <= GATE;
        end
        GATE: begin
          if (gate_cnt == GATE_LAST) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            if (!en) state <= IDLE;
          end else begin
            gate_cnt <= gate_cnt + GATE_W'(1);
            if (edge_now && (edge_cnt != EDGE_MAX)) edge_cnt <= edge_cnt + EDGE_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A fresh result beats a same-cycle handshake; only an unconsumed overwrite is an overrun.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      freq_hz    <= '0;
      meas_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (terminal) begin
      freq_hz    <= result;
      meas_valid <= 1'b1;
      if (meas_valid && !meas_ready) overrun <= 1'b1;
    end else if (meas_valid && meas_ready) begin
      meas_valid <= 1'b0;
    end
  end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 The block SHALL have parameter CLK_IN_FREQ, default 50_000_000, meaning the clk_in frequency in Hz.
REQ-002 The block SHALL have parameter GATE_DIV, default 10, meaning gate windows per second, so the gate is CLK_IN_FREQ/GATE_DIV clk_in cycles long.
REQ-003 The block SHALL have parameter RES_W, default 32, meaning the width of freq_hz.
REQ-004 clk_in  input  1  system clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  measurement enable, synchronous to clk_in.
REQ-007 sig_in  input  1  measured signal, asynchronous to clk_in.
REQ-008 freq_hz  output  RES_W  last measured frequency in Hz.
REQ-009 meas_valid  output  1  freq_hz holds an unconsumed result.
REQ-010 meas_ready  input  1  consumer accepts the result.
REQ-011 overrun  output  1  sticky flag: a result was overwritten before it was consumed.

Function
REQ-012 GATE_CYC SHALL equal CLK_IN_FREQ/GATE_DIV with integer division, and elaboration SHALL fail if GATE_CYC < 4.
REQ-013 sig_in SHALL pass through a 2-flop synchronizer; a rising edge is a synchronized 0->1 transition (edge_now).
REQ-014 The FSM SHALL have states IDLE and GATE: IDLE->GATE when en=1; GATE->IDLE at the terminal gate cycle when en=0.
REQ-015 In GATE, the gate counter SHALL count 0..GATE_CYC-1, and the edge counter SHALL increment on each edge_now.
REQ-016 On the terminal cycle (gate counter = GATE_CYC-1), freq_hz SHALL load (edge_cnt + edge_now) * GATE_DIV, truncated to RES_W bits.
REQ-017 On the terminal cycle, both counters SHALL clear.
REQ-018 If en is still 1 on the terminal cycle, the next window SHALL start on the next cycle with no dead time.
REQ-019 Deasserting en mid-window SHALL NOT abort the window; the window completes and produces a result.
REQ-020 The edge counter width SHALL be $clog2(GATE_CYC/2+1) and SHALL saturate, never wrap.
REQ-021 meas_valid SHALL rise one cycle after the terminal cycle and hold until a cycle with meas_valid=1 and meas_ready=1.
REQ-022 On a new result while meas_valid=1 and meas_ready=0, freq_hz SHALL update, meas_valid SHALL stay 1, and overrun SHALL set.
REQ-023 If the handshake and a new result coincide, the new result SHALL win, meas_valid SHALL stay 1, and overrun SHALL NOT set.
REQ-024 overrun SHALL clear only on reset.
REQ-025 freq_hz SHALL remain stable while meas_valid=1 except as stated in REQ-022 and REQ-023.

Reset
REQ-026 rst_n low SHALL asynchronously force FSM=IDLE, all counters=0, synchronizer flops=0, freq_hz=0, meas_valid=0 and overrun=0.
REQ-027 Reset mid-window SHALL discard the partial count, and no result SHALL be produced for that window.
REQ-028 Reset release SHALL be synchronous-deasserted externally; the block adds no reset synchronizer.

Configuration
REQ-029 With macro FREQ_METER_GLITCH_FILTER_EN defined, a 3-sample majority filter SHALL follow the synchronizer, so edges are detected 2 cycles later and pulses shorter than 2 clk_in cycles are rejected.
REQ-030 Without FREQ_METER_GLITCH_FILTER_EN, edge_now SHALL derive directly from the synchronizer output, and no filter logic SHALL exist.

Structure
REQ-031 Package freq_meter_pkg SHALL hold the FSM state encoding (IDLE=0, GATE=1) and a width helper function computing the edge-counter width from GATE_CYC.
REQ-032 Sub-module sig_sync_edge SHALL contain the synchronizer, the optional filter and the rising-edge detector, with output edge_now.
REQ-033 The gate counter, edge counter, FSM, result register and handshake SHALL reside in freq_meter.

Verification (CLK_IN_FREQ=1000, GATE_DIV=10 -> GATE_CYC=100, filter off unless stated)
REQ-034 en=1, sig_in period 10 cycles, meas_ready=1 -> first freq_hz=100, meas_valid pulses once every 100 cycles.
REQ-035 en=1, sig_in held 0 -> freq_hz=0 with meas_valid asserted; sig_in toggling every cycle -> freq_hz=500, no counter wrap.
REQ-036 meas_ready=0 for two windows, period 20 -> freq_hz=50, meas_valid stays 1, overrun=1 after the second result.
REQ-037 rst_n pulsed low at gate cycle 50 -> all outputs 0 immediately, and the next result appears only after a full 100-cycle window following en.
REQ-038 en dropped at gate cycle 30 -> exactly one result, then FSM IDLE and no further meas_valid.
REQ-039 FREQ_METER_GLITCH_FILTER_EN defined, 1-cycle glitches added to a period-10 signal -> freq_hz=100, and the first edge is detected 2 cycles later than with the filter off.
